// File: rtl/acq_sequencer.sv
// Acquisition scheduler: run/stop/single control, auto-trigger timeout, and
// vblank-aligned buffer swap. Optional frame counter under ACQ_FRAME_COUNT_EN.
module acq_sequencer #(
  parameter int unsigned AUTO_TIMEOUT = 1000000,
  parameter int unsigned HOLDOFF      = 4096,
  parameter int unsigned VBLANK_LINE  = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_single,
  input  logic        mode_auto,
  input  logic        trig_hit,
  input  logic        capture_done,
  input  logic [10:0] vcount,
  output logic        arm,
  output logic        force_trig,
  output logic        swap_req,
  output logic        running,
  output logic [2:0]  state_dbg,
  output logic [15:0] frame_count
);

  localparam int unsigned TO_W = $clog2(AUTO_TIMEOUT) + 1;
  localparam int unsigned HO_W = $clog2(HOLDOFF) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_VBL = 3'd3,
    S_SWAP     = 3'd4,
    S_HOLDOFF  = 3'd5
  } state_t;

  state_t            state, state_d;
  logic              single, single_d;
  logic              stop_pend, stop_pend_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [HO_W-1:0]   ho_cnt, ho_cnt_d;
  logic              force_trig_d;

  // State, flags, timers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      single     <= 1'b0;
      stop_pend  <= 1'b0;
      to_cnt     <= '0;
      ho_cnt     <= '0;
      arm        <= 1'b0;
      force_trig <= 1'b0;
      swap_req   <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_d;
      single     <= single_d;
      stop_pend  <= stop_pend_d;
      to_cnt     <= to_cnt_d;
      ho_cnt     <= ho_cnt_d;
      arm        <= (state_d == S_ARMED);
      force_trig <= force_trig_d;
      swap_req   <= (state_d == S_SWAP);
      running    <= (state_d != S_IDLE);
    end
  end

  assign state_dbg = state;

  // Next-state logic; timers clear whenever their state is not active
  always_comb begin
    state_d      = state;
    single_d     = single;
    stop_pend_d  = stop_pend;
    to_cnt_d     = '0;
    ho_cnt_d     = '0;
    force_trig_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (btn_run) begin
          state_d  = S_ARMED;
          single_d = 1'b0;
        end else if (btn_single) begin
          state_d  = S_ARMED;
          single_d = 1'b1;
        end
      end
      S_ARMED: begin
        if (btn_single) single_d = 1'b1;
        if (btn_run) begin
          state_d     = S_IDLE;
          single_d    = 1'b0;
          stop_pend_d = 1'b0;
        end else if (trig_hit) begin
          state_d = S_CAPTURE;
        end else if (mode_auto && to_cnt == TO_W'(AUTO_TIMEOUT - 1)) begin
          state_d      = S_CAPTURE;
          force_trig_d = 1'b1;
        end else if (mode_auto) begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      S_CAPTURE: begin
        if (btn_run)      stop_pend_d = 1'b1;
        if (btn_single)   single_d    = 1'b1;
        if (capture_done) state_d     = S_WAIT_VBL;
      end
      S_WAIT_VBL: begin
        if (btn_run)    stop_pend_d = 1'b1;
        if (btn_single) single_d    = 1'b1;
        if (vcount == 11'(VBLANK_LINE)) state_d = S_SWAP;
      end
      S_SWAP: begin
        // A stop/single arriving on the swap cycle itself still ends the run
        state_d     = (single || stop_pend || btn_run || btn_single) ? S_IDLE : S_HOLDOFF;
        single_d    = 1'b0;
        stop_pend_d = 1'b0;
      end
      S_HOLDOFF: begin
        if (btn_single) single_d = 1'b1;
        if (btn_run) begin
          state_d     = S_IDLE;
          single_d    = 1'b0;
          stop_pend_d = 1'b0;
        end else if (ho_cnt == HO_W'(HOLDOFF - 1)) begin
          state_d = S_ARMED;
        end else begin
          ho_cnt_d = ho_cnt + HO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ACQ_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  // Completed swaps, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_cnt <= 16'h0000;
    else if (swap_req) frame_cnt <= frame_cnt + 16'd1;
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Acquisition scheduler between the trigger/capture datapath and the display buffer.
- Handles run/stop/single control and auto-trigger timeout.
- Sequences each acquisition as arm -> capture -> wait for vertical blank -> buffer swap -> holdoff.
- Ensures the display buffer only changes during vertical blank, so the drawn trace never tears.

Parameters:
AUTO_TIMEOUT  1000000  cycles armed without trig_hit before force_trig in auto mode (>=2)
HOLDOFF       4096     cycles idle after a swap before re-arming (>=1)
VBLANK_LINE   768      vcount value at which a pending swap is issued

Ports:
clk           in   1   pixel-domain clock
rst           in   1   asynchronous reset, active-high
btn_run       in   1   1-cycle pulse: toggle run/stop
btn_single    in   1   1-cycle pulse: request single acquisition
mode_auto     in   1   1 = auto trigger (timeout forces capture), 0 = normal
trig_hit      in   1   1-cycle pulse: trigger condition met
capture_done  in   1   1-cycle pulse: 256 samples stored in capture buffer
vcount        in   11  current VGA line
arm           out  1   level: trigger comparator enabled
force_trig    out  1   1-cycle pulse: start capture without trigger
swap_req      out  1   1-cycle pulse: copy capture buffer to display buffer
running       out  1   level: acquisition active (any state except IDLE)
state_dbg     out  3   encoded state: IDLE=0, ARMED=1, CAPTURE=2, WAIT_VBL=3, SWAP=4, HOLDOFF=5
frame_count   out  16  completed swaps (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0.
  - Internal flags single and stop_pend are 0.
  - Timers are 0.
- All outputs are registered. Transitions take effect the cycle after the causing input.
- IDLE:
  - btn_run -> ARMED, single=0.
  - btn_single -> ARMED, single=1.
  - If both arrive in the same cycle, btn_run wins.
- ARMED:
  - arm=1. The timeout counter increments each cycle.
  - trig_hit -> CAPTURE.
  - Otherwise, if mode_auto=1 and counter==AUTO_TIMEOUT-1: pulse force_trig for 1 cycle and go to CAPTURE.
  - If trig_hit and timeout coincide, trig_hit wins and no force_trig is issued.
  - With mode_auto=0 the counter is held at 0.
  - On entry the counter clears to 0.
- CAPTURE:
  - arm=0.
  - capture_done -> WAIT_VBL.
  - No timeout; the capture datapath guarantees completion.
- WAIT_VBL: vcount==VBLANK_LINE -> SWAP. If vcount already equals VBLANK_LINE on entry, move on the next cycle.
- SWAP:
  - swap_req=1 for exactly 1 cycle.
  - Next state is IDLE if single=1 or stop_pend=1; otherwise HOLDOFF.
  - single and stop_pend clear when leaving SWAP.
- HOLDOFF: counts HOLDOFF cycles from 0, then -> ARMED.
- Stop (btn_run while running):
  - In ARMED or HOLDOFF: -> IDLE immediately, arm drops next cycle.
  - In CAPTURE, WAIT_VBL or SWAP: set stop_pend. The frame completes and swaps, then the block goes to IDLE.
- btn_single while running: set single=1, so the current acquisition completes and the block then stops.
- Ignored inputs:
  - capture_done outside CAPTURE.
  - trig_hit outside ARMED.
- mode_auto is sampled every cycle. Changing it mid-ARMED affects only the timeout path.
- Counter widths are $clog2(param)+1, so there is no overflow at max parameter.
- Asserting rst mid-operation aborts to IDLE with no swap_req issued.

Optional Feature:
Macro ACQ_FRAME_COUNT_EN.
- Defined: frame_count increments on every swap_req cycle, wraps 0xFFFF->0x0000, and resets to 0.
- Undefined: frame_count is tied to 16'h0000 and no counter logic is generated.
- No other behaviour changes either way.

Test Plan:
Bench parameters for all scenarios: AUTO_TIMEOUT=16, HOLDOFF=4, VBLANK_LINE=5.
1. Normal trigger: btn_run, trig_hit 3 cycles later, capture_done, vcount reaches 5 -> swap_req single pulse, then 4 holdoff cycles, then arm=1 again, state_dbg 1,2,3,4,5,1.
2. Auto timeout: mode_auto=1, btn_run, no trig_hit -> force_trig pulses exactly 16 cycles after arm rises; with mode_auto=0 no force_trig for 100 cycles.
3. Single shot: btn_single, trig_hit, capture_done, vcount=5 -> one swap_req, then running=0, state_dbg=0; subsequent trig_hit ignored.
4. Stop mid-capture: btn_run during CAPTURE -> capture_done and swap still occur, then IDLE; btn_run during HOLDOFF -> IDLE the next cycle with no swap_req.
5. Simultaneous events: trig_hit on the timeout cycle -> no force_trig; btn_run+btn_single in IDLE -> continuous mode (returns to ARMED after holdoff).
6. Async reset asserted in WAIT_VBL -> outputs 0 immediately with no clock edge; with ACQ_FRAME_COUNT_EN, frame_count=0 and it increments to 3 after three swaps.
